// File: rtl/z16_pkg.sv
// Shared constants and types for the Z16 register file family.
//   Z16_DW / Z16_NREG : default data width and register count
//   Z16_AW            : default register address width
//   reg_addr_t/word_t : default-width address and data types
//   Z16_ZERO_REG      : default for the hardwired-zero register option
package z16_pkg;
  localparam int Z16_DW       = 16;
  localparam int Z16_NREG     = 16;
  localparam int Z16_AW       = $clog2(Z16_NREG);
  localparam int Z16_ZERO_REG = 0;

  typedef logic [Z16_AW-1:0] reg_addr_t;
  typedef logic [Z16_DW-1:0] word_t;
endpackage

// File: rtl/z16_scoreboard.sv
// Pending-load scoreboard: one busy bit per register.
//   clk, rst            : clock, async active-high reset
//   mark_we, mark_addr  : load issued, set busy[mark_addr]
//   clr_we, clr_addr    : load writeback, clear busy[clr_addr]
//   rd_addr             : NRD packed read addresses, AW bits each
//   rd_busy             : per-port busy, with same-cycle clear bypassed
//   busy_any            : OR of registered busy bits (no bypass)
module z16_scoreboard
  import z16_pkg::*;
#(
  parameter int NREG     = Z16_NREG,
  parameter int NRD      = 2,
  parameter int ZERO_REG = Z16_ZERO_REG,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mark_we,
  input  logic [AW-1:0]     mark_addr,
  input  logic              clr_we,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              busy_any
);

  logic [NREG-1:0] busy, busy_nxt;

  // Clear first, then set: a new load issued against the register being
  // written back leaves it outstanding.
  always_comb begin
    busy_nxt = busy;
    if (clr_we)  busy_nxt[clr_addr]  = 1'b0;
    if (mark_we) busy_nxt[mark_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
    // Writeback in flight this cycle releases the stall immediately.
    assign rd_busy[k] = busy[a] & ~(clr_we && clr_addr == a)
                      & ~((ZERO_REG != 0) && a == '0);
  end

  assign busy_any = |busy;

endmodule

// File: rtl/z16_regfile_mp.sv
// Multi-port Z16 register file with two write ports and load scoreboard.
//   i_clk, i_rst        : clock, async active-high reset
//   i_rs_addr/o_rs_data : NRD combinational read ports with write bypass
//   o_rs_busy           : per-port pending-load flag (clear bypassed)
//   i_wr0_*             : ALU writeback port (lower priority)
//   i_wr1_*             : load writeback port (higher priority, clears busy)
//   i_mark_we/addr      : mark a register busy when a load issues
//   o_busy_any          : any load outstanding
module z16_regfile_mp
  import z16_pkg::*;
#(
  parameter int DW       = Z16_DW,
  parameter int NREG     = Z16_NREG,
  parameter int NRD      = 2,
  parameter int ZERO_REG = Z16_ZERO_REG,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NRD*AW-1:0] i_rs_addr,
  output logic [NRD*DW-1:0] o_rs_data,
  output logic [NRD-1:0]    o_rs_busy,
  input  logic              i_wr0_we,
  input  logic [AW-1:0]     i_wr0_addr,
  input  logic [DW-1:0]     i_wr0_data,
  input  logic              i_wr1_we,
  input  logic [AW-1:0]     i_wr1_addr,
  input  logic [DW-1:0]     i_wr1_data,
  input  logic              i_mark_we,
  input  logic [AW-1:0]     i_mark_addr,
  output logic              o_busy_any
);

  logic [NREG-1:0][DW-1:0] mem;
  logic                    wr0_ok, wr1_ok;
  logic                    byp0, byp1;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // WP1 wins a same-address collision; the WP0 write is dropped.
  assign wr1_ok = i_wr1_we && !is_zero(i_wr1_addr);
  assign wr0_ok = i_wr0_we && !is_zero(i_wr0_addr)
               && !(i_wr1_we && i_wr1_addr == i_wr0_addr);

  // Bypass is suppressed under reset so outputs read zero while held.
  assign byp1 = i_wr1_we && !i_rst;
  assign byp0 = i_wr0_we && !i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem <= '0;
    end else begin
      if (wr0_ok) mem[i_wr0_addr] <= i_wr0_data;
      if (wr1_ok) mem[i_wr1_addr] <= i_wr1_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    assign a = i_rs_addr[k*AW +: AW];
    always_comb begin
      d = mem[a];
      if (is_zero(a))                          d = '0;
      else if (byp1 && i_wr1_addr == a)        d = i_wr1_data;
      else if (byp0 && i_wr0_addr == a)        d = i_wr0_data;
    end
    assign o_rs_data[k*DW +: DW] = d;
  end

  z16_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (i_clk),
    .rst       (i_rst),
    .mark_we   (i_mark_we),
    .mark_addr (i_mark_addr),
    .clr_we    (i_wr1_we),
    .clr_addr  (i_wr1_addr),
    .rd_addr   (i_rs_addr),
    .rd_busy   (o_rs_busy),
    .busy_any  (o_busy_any)
  );

endmodule

// File: tb/tb_z16_regfile_mp.sv
// Directed bench for z16_regfile_mp: one ZERO_REG=0 and one ZERO_REG=1
// instance driven with identical stimulus.
module tb_z16_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rs_addr;
  logic        wr0_we, wr1_we, mark_we;
  logic [3:0]  wr0_addr, wr1_addr, mark_addr;
  logic [15:0] wr0_data, wr1_data;

  logic [31:0] d_a, d_b;
  logic [1:0]  b_a, b_b;
  logic        any_a, any_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  z16_regfile_mp #(.DW(16), .NREG(16), .NRD(2), .ZERO_REG(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_rs_addr(rs_addr), .o_rs_data(d_a),
    .o_rs_busy(b_a), .i_wr0_we(wr0_we), .i_wr0_addr(wr0_addr),
    .i_wr0_data(wr0_data), .i_wr1_we(wr1_we), .i_wr1_addr(wr1_addr),
    .i_wr1_data(wr1_data), .i_mark_we(mark_we), .i_mark_addr(mark_addr),
    .o_busy_any(any_a));

  z16_regfile_mp #(.DW(16), .NREG(16), .NRD(2), .ZERO_REG(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_rs_addr(rs_addr), .o_rs_data(d_b),
    .o_rs_busy(b_b), .i_wr0_we(wr0_we), .i_wr0_addr(wr0_addr),
    .i_wr0_data(wr0_data), .i_wr1_we(wr1_we), .i_wr1_addr(wr1_addr),
    .i_wr1_data(wr1_data), .i_mark_we(mark_we), .i_mark_addr(mark_addr),
    .o_busy_any(any_b));

  typedef struct {
    logic        w0;  logic [3:0] w0a; logic [15:0] w0d;
    logic        w1;  logic [3:0] w1a; logic [15:0] w1d;
    logic        mk;  logic [3:0] mka;
    logic [3:0]  r0, r1;
    logic [15:0] e0, e1;
    logic        eb0, eb1, eany, ezany;
  } vec_t;

  function automatic vec_t mkv(int w0, int w0a, int w0d, int w1, int w1a,
                               int w1d, int mk, int mka, int r0, int r1,
                               int e0, int e1, int eb0, int eb1, int eany,
                               int ezany);
    vec_t v;
    v.w0 = 1'(w0); v.w0a = 4'(w0a); v.w0d = 16'(w0d);
    v.w1 = 1'(w1); v.w1a = 4'(w1a); v.w1d = 16'(w1d);
    v.mk = 1'(mk); v.mka = 4'(mka);
    v.r0 = 4'(r0); v.r1 = 4'(r1);
    v.e0 = 16'(e0); v.e1 = 16'(e1);
    v.eb0 = 1'(eb0); v.eb1 = 1'(eb1); v.eany = 1'(eany); v.ezany = 1'(ezany);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr0_we = 0; wr0_addr = 0; wr0_data = 0;
    wr1_we = 0; wr1_addr = 0; wr1_data = 0;
    mark_we = 0; mark_addr = 0;
  endtask

  // Both instances; the zero-register build reads 0 / not busy at address 0.
  task automatic chk_both(input string tag, input logic [3:0] r0,
                          input logic [3:0] r1, input logic [15:0] e0,
                          input logic [15:0] e1, input logic eb0,
                          input logic eb1, input logic eany,
                          input logic ezany);
    chk({tag, " a.d0"}, 32'(d_a[15:0]),  32'(e0));
    chk({tag, " a.d1"}, 32'(d_a[31:16]), 32'(e1));
    chk({tag, " a.b0"}, 32'(b_a[0]), 32'(eb0));
    chk({tag, " a.b1"}, 32'(b_a[1]), 32'(eb1));
    chk({tag, " a.any"}, 32'(any_a), 32'(eany));
    chk({tag, " b.d0"}, 32'(d_b[15:0]),  (r0 == 0) ? 32'd0 : 32'(e0));
    chk({tag, " b.d1"}, 32'(d_b[31:16]), (r1 == 0) ? 32'd0 : 32'(e1));
    chk({tag, " b.b0"}, 32'(b_b[0]), (r0 == 0) ? 32'd0 : 32'(eb0));
    chk({tag, " b.b1"}, 32'(b_b[1]), (r1 == 0) ? 32'd0 : 32'(eb1));
    chk({tag, " b.any"}, 32'(any_b), 32'(ezany));
  endtask

  vec_t vt[17];

  initial begin
    vt[0]  = mkv(0,0,0,       0,0,0,        0,0, 3,15, 0,0,           0,0,0,0);
    vt[1]  = mkv(1,10,'h5555, 0,0,0,        0,0, 10,10,'h5555,'h5555, 0,0,0,0);
    vt[2]  = mkv(0,0,0,       0,0,0,        0,0, 10,10,'h5555,'h5555, 0,0,0,0);
    vt[3]  = mkv(1,4,'h1111,  1,4,'h2222,   0,0, 4,10, 'h2222,'h5555, 0,0,0,0);
    vt[4]  = mkv(0,0,0,       0,0,0,        0,0, 4,4,  'h2222,'h2222, 0,0,0,0);
    vt[5]  = mkv(0,0,0,       0,0,0,        1,7, 7,4,  0,'h2222,      0,0,0,0);
    vt[6]  = mkv(0,0,0,       0,0,0,        0,0, 7,10, 0,'h5555,      1,0,1,1);
    vt[7]  = mkv(0,0,0,       1,7,'hBEEF,   0,0, 7,7,  'hBEEF,'hBEEF, 0,0,1,1);
    vt[8]  = mkv(0,0,0,       0,0,0,        0,0, 7,7,  'hBEEF,'hBEEF, 0,0,0,0);
    vt[9]  = mkv(0,0,0,       1,2,'h00FF,   1,2, 2,7,  'h00FF,'hBEEF, 0,0,0,0);
    vt[10] = mkv(0,0,0,       0,0,0,        0,0, 2,7,  'h00FF,'hBEEF, 1,0,1,1);
    vt[11] = mkv(1,2,'h1234,  0,0,0,        0,0, 2,7,  'h1234,'hBEEF, 1,0,1,1);
    vt[12] = mkv(0,0,0,       0,0,0,        0,0, 2,0,  'h1234,0,      1,0,1,1);
    vt[13] = mkv(1,0,'hFFFF,  0,0,0,        1,0, 0,2,  'hFFFF,'h1234, 0,1,1,1);
    vt[14] = mkv(0,0,0,       0,0,0,        0,0, 0,2,  'hFFFF,'h1234, 1,1,1,1);
    vt[15] = mkv(0,0,0,       1,2,'hABCD,   0,0, 2,0,  'hABCD,'hFFFF, 0,1,1,1);
    vt[16] = mkv(0,0,0,       0,0,0,        0,0, 2,0,  'hABCD,'hFFFF, 0,1,1,0);

    // Reset held two cycles, outputs checked while asserted.
    idle();
    rs_addr = {4'hF, 4'h3};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_both("reset", 4'h3, 4'hF, 16'h0, 16'h0, 0, 0, 0, 0);
    rst = 1'b0;

    // Each vector drives on the falling edge, checks combinational outputs
    // before the next rising edge commits it.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wr0_we = vt[i].w0; wr0_addr = vt[i].w0a; wr0_data = vt[i].w0d;
      wr1_we = vt[i].w1; wr1_addr = vt[i].w1a; wr1_data = vt[i].w1d;
      mark_we = vt[i].mk; mark_addr = vt[i].mka;
      rs_addr = {vt[i].r1, vt[i].r0};
      #2;
      chk_both($sformatf("vec%0d", i), vt[i].r0, vt[i].r1, vt[i].e0,
               vt[i].e1, vt[i].eb0, vt[i].eb1, vt[i].eany, vt[i].ezany);
    end

    // Re-marking a busy register keeps it busy until its writeback.
    @(negedge clk); idle(); mark_we = 1; mark_addr = 5; rs_addr = {4'h5, 4'h5};
    @(negedge clk); idle(); mark_we = 1; mark_addr = 5; #2;
    chk("remark.busy_a", 32'(b_a), 32'h3);
    chk("remark.busy_b", 32'(b_b), 32'h3);
    @(negedge clk); idle(); #2;
    chk("remark.hold_a", 32'(b_a), 32'h3);
    chk("remark.anyb",   32'(any_b), 32'h1);
    @(negedge clk); idle(); wr1_we = 1; wr1_addr = 5; wr1_data = 16'h0505; #2;
    chk("wb5.busy_a", 32'(b_a), 32'h0);
    chk("wb5.data_b", d_b, 32'h0505_0505);
    @(negedge clk); idle(); #2;
    chk("wb5.after_a", 32'(b_a), 32'h0);
    chk("wb5.anyb",    32'(any_b), 32'h0);
    chk("wb5.anya",    32'(any_a), 32'h1);

    // Reset pulse over a write and mark to 0x9: both discarded.
    @(negedge clk);
    wr0_we = 1; wr0_addr = 9; wr0_data = 16'h1357;
    mark_we = 1; mark_addr = 9; rs_addr = {4'h5, 4'h9};
    rst = 1'b1; #2;
    chk("rst_mid.d_a",   d_a, 32'h0);
    chk("rst_mid.d_b",   d_b, 32'h0);
    chk("rst_mid.any_a", 32'(any_a), 32'h0);
    @(negedge clk);
    rst = 1'b0; idle(); #2;
    chk("rst_after.d_a", d_a, 32'h0);
    chk("rst_after.d_b", d_b, 32'h0);
    chk("rst_after.b_a", 32'(b_a), 32'h0);
    chk("rst_after.any", 32'({any_a, any_b}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z16_regfile_mp.md
Name: z16_regfile_mp

Overview:
- Parametrised multi-port successor to the Z16 two-read/one-write register file.
- Configurable data width, register count and read-port count.
- Two write ports: WP0 for ALU writeback, WP1 for load writeback, with fixed priority, same-cycle write-to-read bypass and an optional hardwired zero register.
- Integrated pending-load scoreboard (busy bits) that the decode stage uses to stall on RAW hazards against outstanding loads.

Parameters:
- DW, 16, data width in bits.
- NREG, 16, number of registers (power of two, at least 2).
- AW, $clog2(NREG), register address width (derived; do not override).
- NRD, 2, number of read ports (1 to 4).
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_rs_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- o_rs_data  out  NRD*DW  read data; port k occupies bits [k*DW +: DW].
- o_rs_busy  out  NRD  read port k targets a register with a pending load.
- i_wr0_we  in  1  write-enable, port 0 (ALU).
- i_wr0_addr  in  AW  write address, port 0.
- i_wr0_data  in  DW  write data, port 0.
- i_wr1_we  in  1  write-enable, port 1 (load writeback; also clears busy).
- i_wr1_addr  in  AW  write address, port 1.
- i_wr1_data  in  DW  write data, port 1.
- i_mark_we  in  1  mark a register busy (load issued).
- i_mark_addr  in  AW  register to mark busy.
- o_busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): all registers 0, all busy bits 0. Therefore o_rs_data = 0, o_rs_busy = 0 and o_busy_any = 0 during reset.
- Writes: registered on the rising edge, one-cycle latency into the array.
- Same-address simultaneous writes: WP1 wins and the WP0 write is dropped.
- Reads: combinational from array, 0 cycles.
- Bypass per read port, in priority order:
  - if i_wr1_we and i_wr1_addr == rs_addr, return i_wr1_data;
  - else if i_wr0_we and i_wr0_addr == rs_addr, return i_wr0_data;
  - else return the array value.
- ZERO_REG = 1:
  - address 0 always reads 0, including through bypass;
  - writes to 0 are ignored;
  - marks to 0 are ignored;
  - o_rs_busy is 0 for address 0.
- Scoreboard: one busy bit per register.
  - i_mark_we sets busy[i_mark_addr] at the edge.
  - i_wr1_we clears busy[i_wr1_addr] at the edge.
  - Set and clear to the same address in one cycle: set wins (a new load is outstanding). The data write still occurs.
  - WP0 writes do not affect busy bits.
  - Marking an already-busy register keeps it busy (no count, no error).
- o_rs_busy[k] = busy[addr_k] AND NOT (i_wr1_we AND i_wr1_addr == addr_k). The clear is bypassed along with the data, so decode does not stall a cycle late.
- o_busy_any is registered-state based: OR of busy bits, without bypass.
- Reset asserted mid-operation: state clears immediately. Writes and marks presented during reset are discarded.
- Read addresses may repeat across ports; every port is independent.

Decomposition:
- Package z16_pkg:
  - Z16_DW = 16
  - Z16_NREG = 16
  - reg_addr_t and word_t typedefs
  - ZERO_REG default constant
- Sub-module z16_scoreboard holds the NREG busy bits with set/clear logic, set-over-clear priority and per-port bypassed busy lookup. Parameters: NREG, NRD, ZERO_REG.
- z16_regfile_mp instantiates z16_scoreboard and holds the data array plus bypass muxes.

Test Plan:
- Reset then read: i_rst = 1 for 2 cycles; read addr 0x3 and 0xF -> o_rs_data = 0x0000, o_rs_busy = 0, o_busy_any = 0.
- Write then read:
  - WP0 writes 0xA = 0x5555, then stop writing;
  - next cycle port0 reads 0xA -> 0x5555;
  - port1 reads 0xA simultaneously -> 0x5555.
- Bypass and priority: same cycle, WP0 writes 0x4 = 0x1111 and WP1 writes 0x4 = 0x2222, port0 reads 0x4 -> combinational 0x2222; after the edge, array 0x4 reads 0x2222.
- Scoreboard:
  - mark 0x7, then port0 reads 0x7 -> busy = 1, o_busy_any = 1;
  - next cycle WP1 writes 0x7 = 0xBEEF -> same cycle busy = 0 and data = 0xBEEF;
  - after the edge, o_busy_any = 0.
- Set/clear collision: mark 0x2 and WP1 writes 0x2 = 0x00FF in the same cycle -> after the edge busy[2] = 1 and register 2 = 0x00FF.
- ZERO_REG = 1 build:
  - WP0 writes 0x0 = 0xFFFF and marks 0x0 -> reads 0x0000, busy = 0;
  - async reset pulse mid-write to 0x9 -> 0x9 reads 0x0000.
